seven_seg_scanner: RTL and testbench

Parametrised multiplexed seven-segment display driver with the scan timing built in. It replaces the externally clocked 6-digit mux and sits between the display formatting logic and the board pins. It adds:
- its own refresh prescaler on the system clock, with clean index wrap-around;
- per-digit blanking and decimal points;
- dead-time between digits to suppress ghosting;
- PWM brightness control;
- frame-synchronous input snapshots, so the display never tears.

---
 rtl/seven_seg_pkg.sv | 13 +
 rtl/seven_seg_scanner_scan_timer.sv | 74 +++++++
 rtl/seven_seg_scanner.sv | 110 +++++++++++
 tb/tb_seven_seg_scanner.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path: segment width,
// the pattern type used by the hex/char encoders and the scanner, and the
// all-dark pattern.
package seven_seg_pkg;

   localparam int SEG_W = 7;

   // Bit order {g,f,e,d,c,b,a}, 1 = segment lit.
   typedef logic [SEG_W-1:0] seg_pattern_t;

   localparam seg_pattern_t SEG_BLANK = 7'b0;

endpackage

// File: rtl/seven_seg_scanner_scan_timer.sv
// Scan timing for the multiplexed display: per-slot prescaler, digit index
// and the free-running brightness PWM counter. Exposes the current digit,
// whether the slot is past its dead time, and a marker for the first cycle
// of a frame (digit 0, prescaler 0).
module scan_timer
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 6,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 16,
   parameter int BRIGHT_W    = 4
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   output logic [$clog2(NUM_DIGITS)-1:0] idx,
   output logic [BRIGHT_W-1:0]           pwm,
   output logic                          slot_active,
   output logic                          frame_tick
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0] pre;

   // Prescaler: one full count per digit slot, wrapping cleanly to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (pre == PRE_LAST) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // Digit index advances at the end of each slot and never visits unused codes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (pre == PRE_LAST) begin
         if (idx == IDX_LAST) begin
            idx <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Free-running PWM counter compared against the brightness level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm <= '0;
      end else begin
         pwm <= pwm + 1'b1;
      end
   end

   // With no dead time the whole slot is usable, so skip the compare entirely.
   generate
      if (DEAD_CYCLES == 0) begin : g_no_dead
         assign slot_active = 1'b1;
      end else begin : g_dead
         assign slot_active = (pre >= PRE_W'(DEAD_CYCLES));
      end
   endgenerate

   assign frame_tick = (pre == '0) && (idx == '0);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display driver. Inputs are captured once per
// frame into shadow registers so a frame never mixes old and new values;
// the selected digit is gated by dead time, blanking and PWM brightness,
// and every pin is registered with the board polarity applied.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int REFRESH_DIV    = 50000,
   parameter int DEAD_CYCLES    = 16,
   parameter int BRIGHT_W       = 4,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_DIGITS*SEG_W-1:0] digits,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   input  logic [NUM_DIGITS-1:0]       blank,
   input  logic [BRIGHT_W-1:0]         brightness,
   output logic [SEG_W-1:0]            seg,
   output logic                        dp,
   output logic [NUM_DIGITS-1:0]       an,
   output logic                        frame_start
);

   localparam int   IDX_W   = $clog2(NUM_DIGITS);
   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

   logic [IDX_W-1:0]    idx;
   logic [BRIGHT_W-1:0] pwm;
   logic                slot_active;
   logic                frame_tick;

   seg_pattern_t          shadow_digit [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] shadow_dp;
   logic [NUM_DIGITS-1:0] shadow_blank;

   logic                  pwm_on;
   logic                  lit;
   logic [NUM_DIGITS-1:0] an_next;
   seg_pattern_t          seg_next;
   logic                  dp_next;

   scan_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .DEAD_CYCLES (DEAD_CYCLES),
      .BRIGHT_W    (BRIGHT_W)
   ) u_scan_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .idx         (idx),
      .pwm         (pwm),
      .slot_active (slot_active),
      .frame_tick  (frame_tick)
   );

   // Snapshot all digit inputs on the first cycle of each frame only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_digit[i] <= SEG_BLANK;
         end
         shadow_dp    <= '0;
         shadow_blank <= '0;
      end else if (frame_tick) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_digit[i] <= digits[SEG_W*i +: SEG_W];
         end
         shadow_dp    <= dp_in;
         shadow_blank <= blank;
      end
   end

   // Select the current digit; segments stay dark through the dead time so the
   // outgoing pattern never ghosts onto the incoming anode.
   always_comb begin
      pwm_on   = (brightness == '1) || (pwm < brightness);
      lit      = slot_active && !shadow_blank[idx];
      an_next  = '0;
      seg_next = SEG_BLANK;
      dp_next  = 1'b0;
      if (lit) begin
         seg_next = shadow_digit[idx];
         dp_next  = shadow_dp[idx];
         if (pwm_on) begin
            an_next[idx] = 1'b1;
         end
      end
   end

   // Register every pin with board polarity; reset parks them all inactive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an          <= {NUM_DIGITS{AN_INV}};
         seg         <= {SEG_W{SEG_INV}};
         dp          <= SEG_INV;
         frame_start <= 1'b0;
      end else begin
         an          <= an_next ^ {NUM_DIGITS{AN_INV}};
         seg         <= seg_next ^ {SEG_W{SEG_INV}};
         dp          <= dp_next ^ SEG_INV;
         frame_start <= frame_tick;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with 4 digits, 8-cycle slots,
// 2 dead cycles and active-low pins. Expected pins come from a model driven
// by the cycle count since reset release.
module tb_seven_seg_scanner;

   localparam int N     = 4;
   localparam int DIV   = 8;
   localparam int DEAD  = 2;
   localparam int BW    = 4;
   localparam int FRAME = N * DIV;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b1;
   logic [N*7-1:0] digits;
   logic [N-1:0]   dp_in;
   logic [N-1:0]   blank;
   logic [BW-1:0]  brightness;
   logic [6:0]     seg;
   logic           dp;
   logic [N-1:0]   an;
   logic           frame_start;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [6:0]   m_digit [N];
   logic [N-1:0] m_dp;
   logic [N-1:0] m_blank;

   logic [N-1:0] exp_an;
   logic [6:0]   exp_seg;
   logic         exp_dp;
   logic         exp_fs;

   localparam logic [27:0] BASIC = {7'h06, 7'h5B, 7'h4F, 7'h66};

   seven_seg_scanner #(
      .NUM_DIGITS     (N),
      .REFRESH_DIV    (DIV),
      .DEAD_CYCLES    (DEAD),
      .BRIGHT_W       (BW),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digits      (digits),
      .dp_in       (dp_in),
      .blank       (blank),
      .brightness  (brightness),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Model: cycle c after release has slot position c%DIV, digit (c/DIV)%N,
   // pwm c%16; the frame snapshot happens when c is a multiple of FRAME.
   task automatic tick();
      int  pos;
      int  dig;
      int  pw;
      logic on;
      pos = cyc % DIV;
      dig = (cyc / DIV) % N;
      pw  = cyc % 16;
      on  = (brightness == 4'hF) || (pw < int'(brightness));
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      exp_fs  = ((cyc % FRAME) == 0);
      if (pos >= DEAD && !m_blank[dig]) begin
         exp_seg = ~m_digit[dig];
         exp_dp  = ~m_dp[dig];
         if (on) exp_an[dig] = 1'b0;
      end
      if ((cyc % FRAME) == 0) begin
         for (int i = 0; i < N; i++) m_digit[i] = digits[7*i +: 7];
         m_dp    = dp_in;
         m_blank = blank;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Assert reset from a negedge, confirm pins go dark at once, then release.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL %s_async got=%h want=%h", tag,
                  {an, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      for (int i = 0; i < N; i++) m_digit[i] = 7'h00;
      m_dp    = '0;
      m_blank = '0;
   endtask

   task automatic test_reset();
      digits     = BASIC;
      dp_in      = '0;
      blank      = '0;
      brightness = 4'hF;
      #2;
      apply_reset("reset");
      vectors++;
      if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL reset_release got=%h want=%h",
                  {an, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
   endtask

   task automatic test_basic_scan();
      digits = BASIC; dp_in = '0; blank = '0; brightness = 4'hF;
      apply_reset("basic");
      for (int k = 0; k < 70; k++) begin
         tick();
         vectors++;
         if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
            miscompares++;
            $display("[TB] FAIL basic_scan cyc=%0d got=%h want=%h", cyc,
                     {an, seg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
         end
         if (cyc == 1 || cyc == 33 || cyc == 65) begin
            vectors++;
            if (frame_start !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL basic_frame_start cyc=%0d got=%b want=1", cyc, frame_start);
            end
         end
         if (cyc == 2 || cyc == 3 || cyc == 11) begin
            vectors++;
            if ({an, seg} !== ((cyc == 2) ? {4'b1111, 7'h7F} :
                               (cyc == 3) ? {4'b1110, 7'h19} : {4'b1101, 7'h30})) begin
               miscompares++;
               $display("[TB] FAIL basic_fixed cyc=%0d got an=%b seg=%h", cyc, an, seg);
            end
         end
      end
   endtask

   task automatic test_wraparound();
      digits = {$urandom, $urandom};
      dp_in  = 4'($urandom);
      blank  = '0;
      brightness = 4'hF;
      apply_reset("wrap");
      for (int k = 0; k < 100; k++) begin
         tick();
         vectors++;
         if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
            miscompares++;
            $display("[TB] FAIL wraparound cyc=%0d got=%h want=%h", cyc,
                     {an, seg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
         end
         vectors++;
         if ($countones(~an) > 1) begin
            miscompares++;
            $display("[TB] FAIL wrap_onehot cyc=%0d got an=%b want at most one low", cyc, an);
         end
      end
   endtask

   task automatic test_snapshot();
      digits = BASIC; dp_in = '0; blank = '0; brightness = 4'hF;
      apply_reset("snap");
      for (int k = 0; k < 45; k++) begin
         if (cyc == 12) digits[6:0] = 7'h3F;
         tick();
         vectors++;
         if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
            miscompares++;
            $display("[TB] FAIL snapshot cyc=%0d got=%h want=%h", cyc,
                     {an, seg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
         end
         if (cyc == 35) begin
            vectors++;
            if (seg !== 7'h40) begin
               miscompares++;
               $display("[TB] FAIL snapshot_new cyc=35 got seg=%h want 40", seg);
            end
         end
      end
   endtask

   task automatic test_blank_dp();
      digits = BASIC; dp_in = 4'b0001; blank = 4'b0010; brightness = 4'hF;
      apply_reset("blank");
      for (int k = 0; k < 40; k++) begin
         tick();
         vectors++;
         if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
            miscompares++;
            $display("[TB] FAIL blank_dp cyc=%0d got=%h want=%h", cyc,
                     {an, seg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
         end
         vectors++;
         if (an[1] !== 1'b1 || (cyc >= 9 && cyc <= 16 && seg !== 7'h7F) ||
             (cyc >= 3 && cyc <= 8 && dp !== 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL blank_fixed cyc=%0d got an=%b seg=%h dp=%b", cyc, an, seg, dp);
         end
      end
   endtask

   task automatic test_brightness();
      int on_cnt;
      digits = BASIC; dp_in = '0; blank = '0; brightness = 4'd8;
      apply_reset("bright");
      on_cnt = 0;
      for (int k = 0; k < 64; k++) begin
         tick();
         vectors++;
         if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
            miscompares++;
            $display("[TB] FAIL bright8 cyc=%0d got=%h want=%h", cyc,
                     {an, seg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
         end
         if (an != 4'hF) on_cnt++;
      end
      vectors++;
      if (on_cnt != 24) begin
         miscompares++;
         $display("[TB] FAIL bright8_duty got=%0d want=24 of 48 window cycles", on_cnt);
      end
      brightness = 4'd0;
      for (int k = 0; k < 32; k++) begin
         tick();
         vectors++;
         if (an !== 4'hF || {an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
            miscompares++;
            $display("[TB] FAIL bright0 cyc=%0d got=%h want=%h", cyc,
                     {an, seg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
         end
      end
   endtask

   task automatic test_mid_frame_reset();
      digits = BASIC; dp_in = 4'b1010; blank = '0; brightness = 4'hF;
      apply_reset("mid_pre");
      while (cyc < 20) tick();
      apply_reset("mid_frame");
      for (int k = 0; k < 40; k++) begin
         tick();
         vectors++;
         if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs} ||
             (cyc == 1 && frame_start !== 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL mid_reset cyc=%0d got=%h want=%h", cyc,
                     {an, seg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset("rand");
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 5) == 0) digits = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
         if ($urandom_range(0, 9) == 0) blank = 4'($urandom);
         brightness = 4'($urandom);
         tick();
         vectors++;
         if ({an, seg, dp, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
            miscompares++;
            $display("[TB] FAIL random cyc=%0d got=%h want=%h", cyc,
                     {an, seg, dp, frame_start}, {exp_an, exp_seg, exp_dp, exp_fs});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_wraparound();
      test_snapshot();
      test_blank_dp();
      test_brightness();
      test_mid_frame_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout got=running want=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
